// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-port round-robin arbiter/sequencer in front of data_memory.
//             Port 0 is the core load/store unit, port 1 is the program/data
//             loader. One transaction is in flight at a time: the winner is
//             captured in IDLE, the memory strobe is issued for one cycle,
//             read latency is waited out, and a one-cycle ack is returned.
//  Ports    : clk, reset (async assert, active-low, sync release)
//             req[1:0], we[1:0], addr0/1, wdata0/1   requester side
//             ack[1:0], rdata, busy                  completion side
//             mem_read, mem_write, mem_addr,
//             mem_wdata, mem_rdata                   memory side
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1     // 1..7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(READ_LAT - 1);

    // ------------------------------------------------------------------
    // Reset synchroniser: assertion is immediate, release is aligned to
    // clk through two flops so the FSM never leaves reset mid-cycle.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic               gnt_q,       gnt_d;
    logic               we_q,        we_d;
    logic               rr_q,        rr_d;
    logic [2:0]         cnt_q,       cnt_d;
    logic [1:0]         ack_q,       ack_d;
    logic [DATA_W-1:0]  rdata_q,     rdata_d;
    logic               mem_read_q,  mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               gnt_sel;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= S_IDLE;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            rr_q        <= 1'b1;       // port 0 wins the first tie
            cnt_q       <= 3'd0;
            ack_q       <= 2'b00;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Strobes and ack are computed one cycle ahead so
    // that they come straight out of flops while in ISSUE / ACK.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        ack_d       = 2'b00;
        rdata_d     = rdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        gnt_sel     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the port that did not win last time is served.
                    gnt_sel     = (req == 2'b11) ? ~rr_q : req[1];
                    gnt_d       = gnt_sel;
                    rr_d        = gnt_sel;
                    we_d        = we[gnt_sel];
                    // The captured address/data live directly in the memory
                    // output registers, which also hold them after ISSUE.
                    mem_addr_d  = gnt_sel ? addr1  : addr0;
                    mem_wdata_d = gnt_sel ? wdata1 : wdata0;
                    mem_read_d  = ~we[gnt_sel];
                    mem_write_d = we[gnt_sel];
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (we_q) begin
                    ack_d   = gnt_q ? 2'b10 : 2'b01;
                    state_d = S_ACK;
                end else if (READ_LAT == 1) begin
                    rdata_d = mem_rdata;
                    ack_d   = gnt_q ? 2'b10 : 2'b01;
                    state_d = S_ACK;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // WAIT spans READ_LAT-1 cycles; data is taken on the edge
                // that ends the last one, so ack lands READ_LAT cycles
                // after the strobe cycle.
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = mem_rdata;
                    ack_d   = gnt_q ? 2'b10 : 2'b01;
                    cnt_d   = 3'd0;
                    state_d = S_ACK;
                end
            end

            S_ACK: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Scoreboard bench for dmem_arbiter. Two instances (READ_LAT 1
//             and 3) share the requester stimulus, each with its own memory
//             model. Expected strobes and acks are queued by the stimulus and
//             popped by a negedge monitor whenever a DUT presents them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] req, we;
    logic [7:0] addr0, addr1, wdata0, wdata1;

    logic [1:0] ack1, ack3;
    logic [7:0] rdata1, rdata3, ma1, ma3, mwd1, mwd3, mrd1, mrd3;
    logic       busy1, busy3, mr1, mr3, mw1, mw3;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack1), .rdata(rdata1), .busy(busy1),
        .mem_read(mr1), .mem_write(mw1), .mem_addr(ma1),
        .mem_wdata(mwd1), .mem_rdata(mrd1)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack3), .rdata(rdata3), .busy(busy3),
        .mem_read(mr3), .mem_write(mw3), .mem_addr(ma3),
        .mem_wdata(mwd3), .mem_rdata(mrd3)
    );

    // ---------------- memory models ----------------
    // Read data is valid only in cycle (strobe + READ_LAT - 1), zero otherwise.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] pipe3;

    always @(posedge clk) begin
        if (mw1) mem1[ma1] <= mwd1;
        if (mw3) mem3[ma3] <= mwd3;
        pipe3 <= {pipe3[6:0], mr3};
    end

    assign mrd1 = mr1      ? mem1[ma1] : 8'h00;
    assign mrd3 = pipe3[1] ? mem3[ma3] : 8'h00;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int port; bit rd; logic [7:0] data; int cyc; } ack_t;
    typedef struct { bit wr; logic [7:0] addr; logic [7:0] wdata; int cyc; } stb_t;

    ack_t aq1[$], aq3[$];
    stb_t sq1[$], sq3[$];

    task automatic mon(input int i, input logic [1:0] ack, input logic [7:0] rdata,
                       input logic mr, input logic mw, input logic [7:0] ma,
                       input logic [7:0] mwd);
        stb_t s;
        ack_t a;
        bit   have;
        if (mr || mw) begin
            checks++;
            have = (i == 0) ? (sq1.size() > 0) : (sq3.size() > 0);
            if (!have) begin
                errors++;
                $display("FAIL strobe_unexpected lat%0d cyc=%0d rd=%b wr=%b addr=%h",
                         (i == 0) ? 1 : 3, cyc, mr, mw, ma);
            end else begin
                s = (i == 0) ? sq1.pop_front() : sq3.pop_front();
                if (mr != !s.wr || mw != s.wr || ma != s.addr || cyc != s.cyc ||
                    (s.wr && mwd != s.wdata)) begin
                    errors++;
                    $display("FAIL strobe lat%0d got cyc=%0d rd=%b wr=%b addr=%h wd=%h exp cyc=%0d wr=%b addr=%h wd=%h",
                             (i == 0) ? 1 : 3, cyc, mr, mw, ma, mwd, s.cyc, s.wr, s.addr, s.wdata);
                end
            end
        end
        if (ack != 2'b00) begin
            checks++;
            have = (i == 0) ? (aq1.size() > 0) : (aq3.size() > 0);
            if (!have) begin
                errors++;
                $display("FAIL ack_unexpected lat%0d cyc=%0d ack=%b", (i == 0) ? 1 : 3, cyc, ack);
            end else begin
                a = (i == 0) ? aq1.pop_front() : aq3.pop_front();
                if (ack != (2'b01 << a.port) || cyc != a.cyc || (a.rd && rdata != a.data)) begin
                    errors++;
                    $display("FAIL ack lat%0d got cyc=%0d ack=%b rdata=%h exp cyc=%0d port=%0d rd=%b rdata=%h",
                             (i == 0) ? 1 : 3, cyc, ack, rdata, a.cyc, a.port, a.rd, a.data);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon(0, ack1, rdata1, mr1, mw1, ma1, mwd1);
            mon(1, ack3, rdata3, mr3, mw3, ma3, mwd3);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request sampled at the end of cycle c: strobe in c+1, ack at c+2 for a
    // write, c+1+READ_LAT for a read.
    task automatic expect_txn(input int port, input bit wr, input logic [7:0] a,
                              input logic [7:0] wd, input logic [7:0] rd, input int c,
                              input bit with_ack);
        sq1.push_back('{wr: wr, addr: a, wdata: wd, cyc: c + 1});
        sq3.push_back('{wr: wr, addr: a, wdata: wd, cyc: c + 1});
        if (with_ack) begin
            aq1.push_back('{port: port, rd: !wr, data: rd, cyc: wr ? c + 2 : c + 2});
            aq3.push_back('{port: port, rd: !wr, data: rd, cyc: wr ? c + 2 : c + 4});
        end
    endtask

    task automatic drain(input string nm);
        checks++;
        if (aq1.size() != 0 || aq3.size() != 0 || sq1.size() != 0 || sq3.size() != 0) begin
            errors++;
            $display("FAIL %s_missing got pending acks=%0d/%0d strobes=%0d/%0d exp 0",
                     nm, aq1.size(), aq3.size(), sq1.size(), sq3.size());
        end
        aq1.delete(); aq3.delete(); sq1.delete(); sq3.delete();
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if ({ack1, rdata1, busy1, mr1, mw1, ma1, mwd1} != '0 ||
            {ack3, rdata3, busy3, mr3, mw3, ma3, mwd3} != '0) begin
            errors++;
            $display("FAIL %s got ack=%b/%b rdata=%h/%h busy=%b/%b rd=%b/%b wr=%b/%b addr=%h/%h wd=%h/%h exp all 0",
                     nm, ack1, ack3, rdata1, rdata3, busy1, busy3, mr1, mr3, mw1, mw3,
                     ma1, ma3, mwd1, mwd3);
        end
    endtask

    // ---------------- directed sequence ----------------
    int c;
    initial begin
        for (int k = 0; k < 256; k++) begin
            mem1[k] = 8'h00;
            mem3[k] = 8'h00;
        end
        mem1[8'h3C] = 8'h5A; mem3[8'h3C] = 8'h5A;
        mem1[8'h01] = 8'h77; mem3[8'h01] = 8'h77;
        mem1[8'hFF] = 8'hEE; mem3[8'hFF] = 8'hEE;
        pipe3  = 8'h00;
        reset  = 1'b0;
        req    = 2'b00; we = 2'b00;
        addr0  = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;

        repeat (3) tick();
        check_zero("reset_values");
        reset = 1'b1;
        repeat (4) tick();

        // Idle: nothing requested for 20 cycles
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (busy1 || busy3 || mr1 || mw1 || mr3 || mw3 || ack1 != 2'b00 || ack3 != 2'b00) begin
                errors++;
                $display("FAIL idle cyc=%0d got busy=%b/%b rd=%b/%b wr=%b/%b ack=%b/%b exp all 0",
                         cyc, busy1, busy3, mr1, mr3, mw1, mw3, ack1, ack3);
            end
        end

        // Single write on port 0
        c = cyc; req = 2'b01; we = 2'b01; addr0 = 8'h10; wdata0 = 8'hA5;
        expect_txn(0, 1'b1, 8'h10, 8'hA5, 8'h00, c, 1'b1);
        tick(); req = 2'b00; we = 2'b00;
        repeat (6) tick();
        drain("write");

        // Single read on port 1
        c = cyc; req = 2'b10; we = 2'b00; addr1 = 8'h3C;
        expect_txn(1, 1'b0, 8'h3C, 8'h00, 8'h5A, c, 1'b1);
        tick(); req = 2'b00;
        repeat (8) tick();
        drain("read");

        // Address changes during ISSUE must not reach the memory
        c = cyc; req = 2'b01; we = 2'b00; addr0 = 8'h01;
        expect_txn(0, 1'b0, 8'h01, 8'h00, 8'h77, c, 1'b1);
        tick(); addr0 = 8'hFF; req = 2'b00;
        repeat (8) tick();
        drain("addr_hold");

        // Reset in the middle of a READ_LAT=3 read: no ack may follow
        c = cyc; req = 2'b01; we = 2'b00; addr0 = 8'h3C;
        expect_txn(0, 1'b0, 8'h3C, 8'h00, 8'h00, c, 1'b0);
        tick(); req = 2'b00;
        tick();
        checks++;
        if (busy3 !== 1'b1) begin
            errors++;
            $display("FAIL abort_precond got busy3=%b exp 1", busy3);
        end
        #1 reset = 1'b0;
        #1 check_zero("reset_async");
        repeat (3) tick();
        drain("abort");
        reset = 1'b1;
        repeat (4) tick();

        // Contention: both ports writing continuously, port 0 first after reset
        c = cyc; req = 2'b11; we = 2'b11;
        addr0 = 8'h20; wdata0 = 8'h11; addr1 = 8'h30; wdata1 = 8'h22;
        for (int t = 0; t < 6; t++) begin
            if (t % 2 == 0) expect_txn(0, 1'b1, 8'h20, 8'h11, 8'h00, c + 3 * t, 1'b1);
            else            expect_txn(1, 1'b1, 8'h30, 8'h22, 8'h00, c + 3 * t, 1'b1);
        end
        repeat (16) tick();
        req = 2'b00; we = 2'b00;
        repeat (6) tick();
        drain("contention");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
